// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if
//   Bundles the load handshake and the display-side outputs of the
//   seven-segment scanner.
//   Signals:
//     load         - request to capture value (master -> slave)
//     value        - 4*NUM_DIGITS hex digits, digit 0 in bits [3:0]
//     load_ready   - high when a load will be accepted (slave -> master)
//     digit_nibble - code of the currently scanned digit
//     anode_n      - active-low digit enables, at most one low
//     frame_done   - one-cycle pulse on the last cycle of each frame
//   Modports: master (value source / observer), slave (scanner).
interface seven_seg_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load_ready;
    logic [3:0]              digit_nibble;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    frame_done;

    modport master (
        output load,
        output value,
        input  load_ready,
        input  digit_nibble,
        input  anode_n,
        input  frame_done
    );

    modport slave (
        input  load,
        input  value,
        output load_ready,
        output digit_nibble,
        output anode_n,
        output frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scan driver for a common-anode seven-segment display.
//   Each digit slot is REFRESH_DIV cycles: GUARD_CYCLES with all anodes off,
//   then the slot's digit enabled. New values go through a one-deep pending
//   register and are applied to the displayed value only at frame boundaries.
//   Ports:
//     clk   - clock
//     rst_n - asynchronous active-low reset
//     bus   - seven_seg_scanner_if.slave (load/value/load_ready handshake,
//             digit_nibble, anode_n, frame_done; all outputs registered)
//   Optional feature: define LEADING_ZERO_BLANK_EN to keep slots above the
//   most significant nonzero digit dark (digit 0 always lit).
module seven_seg_scanner #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD_CYCLES = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    seven_seg_scanner_if.slave bus
);
    localparam int unsigned   CW         = $clog2(REFRESH_DIV);
    localparam int unsigned   IW         = $clog2(NUM_DIGITS);
    localparam int unsigned   VW         = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD_CYCLES == 0) ? '0 : CW'(GUARD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {GUARD, ON} phase_t;

    phase_t                r_phase, w_phase_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic [VW-1:0]         r_disp, w_disp_nxt;
    logic [VW-1:0]         r_pend;
    logic                  r_pend_valid, w_pend_valid_nxt;
    logic [3:0]            r_digit_nibble, w_nibble_nxt;
    logic [NUM_DIGITS-1:0] r_anode_n, w_anode_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    logic                  w_slot_end, w_boundary, w_load_acc, w_lit;
`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0]         w_top;
`endif

    // Phase state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_phase <= GUARD;
        else        r_phase <= w_phase_nxt;
    end

    // Next-state and registered-output precompute. Outputs are registered
    // from next-state values so they line up with the state they describe.
    always_comb begin
        w_slot_end  = (r_cnt == CNT_LAST);
        w_boundary  = w_slot_end && (r_idx == IDX_LAST);
        w_load_acc  = bus.load && !r_pend_valid;

        w_cnt_nxt   = w_slot_end ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        if (w_slot_end)
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

        w_phase_nxt = r_phase;
        case (r_phase)
            GUARD:   if (GUARD_CYCLES == 0 || r_cnt == GUARD_LAST) w_phase_nxt = ON;
            ON:      if (w_slot_end) w_phase_nxt = (GUARD_CYCLES == 0) ? ON : GUARD;
            default: w_phase_nxt = GUARD;
        endcase

        // Boundary transfer uses the pending flag as it stood before this
        // cycle, so a load accepted on the boundary waits a full frame.
        w_disp_nxt       = r_disp;
        w_pend_valid_nxt = r_pend_valid;
        if (w_boundary && r_pend_valid) begin
            w_disp_nxt       = r_pend;
            w_pend_valid_nxt = 1'b0;
        end
        if (w_load_acc)
            w_pend_valid_nxt = 1'b1;

        w_nibble_nxt = r_digit_nibble;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (w_cnt_nxt == '0 && IW'(d) == w_idx_nxt)
                w_nibble_nxt = w_disp_nxt[4*d +: 4];
        end

`ifdef LEADING_ZERO_BLANK_EN
        w_top = '0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (w_disp_nxt[4*d +: 4] != 4'h0)
                w_top = IW'(d);
        end
        w_lit = (w_idx_nxt <= w_top);
`else
        w_lit = 1'b1;
`endif

        w_anode_nxt = '1;
        if (w_phase_nxt == ON && w_lit) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                if (IW'(d) == w_idx_nxt)
                    w_anode_nxt[d] = 1'b0;
            end
        end

        w_frame_done_nxt = (w_idx_nxt == IDX_LAST) && (w_cnt_nxt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_disp         <= '0;
            r_pend         <= '0;
            r_pend_valid   <= 1'b0;
            r_digit_nibble <= '0;
            r_anode_n      <= '1;
            r_frame_done   <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_nxt;
            r_idx          <= w_idx_nxt;
            r_disp         <= w_disp_nxt;
            r_pend_valid   <= w_pend_valid_nxt;
            r_digit_nibble <= w_nibble_nxt;
            r_anode_n      <= w_anode_nxt;
            r_frame_done   <= w_frame_done_nxt;
            if (w_load_acc)
                r_pend <= bus.value;
        end
    end

    assign bus.load_ready   = !r_pend_valid;
    assign bus.digit_nibble = r_digit_nibble;
    assign bus.anode_n      = r_anode_n;
    assign bus.frame_done   = r_frame_done;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Scoreboard bench for seven_seg_scanner (NUM_DIGITS=4, REFRESH_DIV=8,
//   GUARD_CYCLES=2). A reference model derives every expected output from
//   elapsed cycles since reset and the displayed/pending values; a monitor
//   on the falling edge pops and compares.
module tb_seven_seg_scanner;
    localparam int unsigned N  = 4;
    localparam int unsigned R  = 8;
    localparam int unsigned G  = 2;
    localparam int unsigned NR = N * R;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .GUARD_CYCLES(G)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0] anode_n;
        logic [3:0] nibble;
        logic       frame_done;
        logic       load_ready;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference model state
    int unsigned k      = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    logic        m_pv   = 1'b0;

    function automatic exp_t model_out(input int unsigned t, input logic [15:0] disp, input logic pv);
        int unsigned p;
        int unsigned slot;
        int unsigned c;
        logic        lit;
        logic [3:0]  sel;
        exp_t        e;
        p    = t % NR;
        slot = p / R;
        c    = p % R;
        lit  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        lit  = (slot == 0) || ((disp >> (4 * slot)) != 16'h0);
`endif
        sel          = 4'b0001 << slot;
        e.anode_n    = (c < G || !lit) ? 4'hF : ~sel;
        e.nibble     = 4'((disp >> (4 * slot)) & 16'hF);
        e.frame_done = (p == NR - 1);
        e.load_ready = !pv;
        return e;
    endfunction

    always @(posedge clk) begin
        logic old_pv;
        if (!rst_n) begin
            k      = 0;
            m_disp = '0;
            m_pv   = 1'b0;
        end else begin
            old_pv = m_pv;
            if ((k % NR) == NR - 1 && old_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
            if (bus.load && !old_pv) begin
                m_pend = bus.value;
                m_pv   = 1'b1;
            end
            k++;
        end
        exp_q.push_back(model_out(k, m_disp, m_pv));
    end

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {bus.anode_n, bus.digit_nibble, bus.frame_done, bus.load_ready};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL scan k=%0d: got anode_n=%b nibble=%h frame_done=%b load_ready=%b, expected anode_n=%b nibble=%h frame_done=%b load_ready=%b",
                         k, a.anode_n, a.nibble, a.frame_done, a.load_ready,
                         e.anode_n, e.nibble, e.frame_done, e.load_ready);
            end
        end
    end

    task automatic do_load(input logic [15:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic run(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Advance (bounded) until the current state sits at frame position p.
    task automatic wait_pos(input int unsigned p);
        int unsigned guard_cnt;
        guard_cnt = 0;
        while ((k % NR) != p && guard_cnt <= NR) begin
            @(negedge clk);
            guard_cnt++;
        end
        if ((k % NR) != p) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_pos: reached position %0d, required %0d", k % NR, p);
        end
    endtask

    initial begin
        logic [15:0] masks [5];
        masks[0] = 16'h000F;
        masks[1] = 16'h00FF;
        masks[2] = 16'h0FFF;
        masks[3] = 16'hFFFF;
        masks[4] = 16'h0000;
        bus.load  = 1'b0;
        bus.value = '0;
        #2 rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;

        // Basic scan of 1234
        do_load(16'h1234);
        run(3 * NR);

        // Second load while pending is ignored
        do_load(16'hAAAA);
        do_load(16'h5555);
        run(2 * NR + 4);

        // Load exactly on the boundary cycle with pend empty
        wait_pos(NR - 1);
        do_load(16'h9C3E);
        run(2 * NR + 2);

        // Leading-zero cases (all digits lit when blanking is not built in)
        do_load(16'h0070);
        run(2 * NR + 2);
        do_load(16'h0000);
        run(2 * NR + 2);
        do_load(16'h0B00);
        run(2 * NR + 2);

        // Randomized loads
        repeat (700) begin
            bus.load  = ($urandom_range(0, 5) == 0);
            bus.value = 16'($urandom) & masks[$urandom_range(0, 4)];
            @(negedge clk);
        end
        bus.load = 1'b0;
        run(2 * NR);

        // Reset in the ON phase of digit 2 with a load just queued
        wait_pos(2 * R + 2);
        do_load(16'hFEDC);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.anode_n !== 4'hF || bus.digit_nibble !== 4'h0 ||
            bus.frame_done !== 1'b0 || bus.load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got anode_n=%b nibble=%h frame_done=%b load_ready=%b, expected 1111 0 0 1",
                     bus.anode_n, bus.digit_nibble, bus.frame_done, bus.load_ready);
        end
        run(3);
        rst_n = 1'b1;
        run(2 * NR);
        do_load(16'h4321);
        run(3 * NR);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed scan driver for a multi-digit common-anode seven-segment display. Holds a multi-digit hex value, walks through the digits one at a time, and presents the active digit's 4-bit code to the downstream seven-segment decoder on `digit_nibble`. Drives active-low digit enables with an all-off guard interval at each digit change to suppress ghosting. New values are accepted through a one-deep load handshake and applied only on frame boundaries, so a scan never displays a mix of old and new digits.

## Interface

Parameters:

- `NUM_DIGITS`, 4: number of digits scanned; must be ≥ 2.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be ≥ 2.
- `GUARD_CYCLES`, 500: cycles at the start of each slot with all digits off; must be < `REFRESH_DIV`.

Ports:

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `load` in 1: request to capture `value`.
- `value` in 4*`NUM_DIGITS`: hex digits; digit 0 = bits [3:0] (least significant).
- `load_ready` out 1: high when a `load` will be accepted.
- `digit_nibble` out 4: code of the current digit; feeds the decoder input.
- `anode_n` out `NUM_DIGITS`: active-low digit enables; at most one bit low at any time.
- `frame_done` out 1: one-cycle pulse on the last cycle of the final digit's slot.

## Operation

- Internal state:
  - `disp` register (value shown).
  - `pend` register with `pend_valid` flag.
  - Digit index `idx`, 0..`NUM_DIGITS`-1.
  - Slot counter `cnt`, 0..`REFRESH_DIV`-1.
  - Phase FSM: GUARD, ON.
- Handshake:
  - `load_ready` = !`pend_valid`.
  - If `load` and `load_ready` are both high: `pend` <= `value`, `pend_valid` <= 1.
  - `load` while `load_ready` is low is ignored. There is no error flag.
- Frame boundary: the cycle where `idx` = `NUM_DIGITS`-1 and `cnt` = `REFRESH_DIV`-1.
  - If `pend_valid`: `disp` <= `pend`, `pend_valid` <= 0.
  - If a load is accepted in the boundary cycle itself, it goes to `pend` and is applied at the next boundary. It never bypasses into `disp`.
- FSM:
  - GUARD: `anode_n` all 1. When `cnt` = `GUARD_CYCLES`-1, go to ON.
  - ON: the `idx` bit of `anode_n` is 0. When `cnt` = `REFRESH_DIV`-1, go to GUARD, set `cnt` <= 0, and set `idx` <= `idx`+1 (wraps from `NUM_DIGITS`-1 to 0).
  - If `GUARD_CYCLES` = 0, GUARD is skipped and every slot is entirely ON.
- `digit_nibble` is loaded with `disp` digit `idx` at slot start (`cnt` = 0). It is held constant for the whole slot.
- The digit for the slot that follows a frame boundary uses the newly transferred `disp`.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset values:
  - `anode_n` = all 1.
  - `digit_nibble` = 0.
  - `frame_done` = 0.
  - `load_ready` = 1.
  - Internal: `disp` = 0, `pend_valid` = 0, `idx` = 0, `cnt` = 0, FSM = GUARD.
- `load_ready` falls one cycle after an accepted load. It rises one cycle after the frame boundary that consumes `pend`.
- Worst-case load-to-display latency: one frame (`NUM_DIGITS`*`REFRESH_DIV` cycles) plus one cycle.
- Frame period: `NUM_DIGITS`*`REFRESH_DIV` cycles. `frame_done` asserts exactly once per frame.
- Reset asserted mid-scan: all outputs go immediately (asynchronously) to reset values, and any pending load is discarded. After release, scanning restarts at digit 0, GUARD phase.

## Configuration

- `LEADING_ZERO_BLANK_EN`:
  - Defined: in any slot whose digit index is above the most significant nonzero digit of `disp`, `anode_n` stays all 1 for the entire slot. Digit 0 is always lit, so a value of 0 shows a single "0". Slot timing and `frame_done` are unchanged.
  - Undefined: every digit is lit during its ON phase regardless of value.

## Test plan

Use `NUM_DIGITS`=4, `REFRESH_DIV`=8, `GUARD_CYCLES`=2.

- Reset, then load 16'h1234 → after the first boundary, per slot: cycles 0-1 have `anode_n` = 4'b1111; cycles 2-7 show `anode_n` = 1110/1101/1011/0111 with `digit_nibble` = 4/3/2/1. `frame_done` pulses every 32 cycles.
- Load 16'hAAAA, then load 16'h5555 while `load_ready` = 0 → the second load is ignored and only AAAA is displayed. `load_ready` returns to 1 one cycle after the boundary.
- Load asserted exactly on a boundary cycle with `pend` empty → current frame keeps the old `disp`; the new value appears after the following boundary.
- Assert `rst_n` low mid-ON-phase of digit 2 → `anode_n` = 1111 immediately; after release the scan restarts at digit 0, GUARD.
- With `LEADING_ZERO_BLANK_EN`, load 16'h0070 → digits 2 and 3 stay dark; digit 1 shows 7 and digit 0 shows 0. Load 16'h0000 → only digit 0 is lit.
- Across a full frame → never more than one `anode_n` bit low, and no `digit_nibble` change during an ON phase.
